// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: default widths, reset vector,
// major opcodes and the fetch FSM state type.
package riscv_pkg;

  localparam int          XLEN_DEFAULT     = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam logic [6:0] OPC_RT  = 7'b0110011;
  localparam logic [6:0] OPC_LW  = 7'b0000011;
  localparam logic [6:0] OPC_SW  = 7'b0100011;
  localparam logic [6:0] OPC_BEQ = 7'b1100011;

  typedef enum logic [1:0] {
    FETCH_REQ  = 2'd0,
    FETCH_WAIT = 2'd1,
    FETCH_HOLD = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/if_fifo.sv
// Two-entry {pc, instr} buffer between fetch and decode. The head entry is
// held in registers so decode sees registered outputs.
module if_fifo
  import riscv_pkg::*;
#(
  parameter int W = XLEN_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] push_pc,
  input  logic [W-1:0] push_instr,
  output logic [W-1:0] head_pc,
  output logic [W-1:0] head_instr,
  output logic [1:0]   count
);

  logic [W-1:0] tail_pc;
  logic [W-1:0] tail_instr;

  // Flush only clears occupancy; stale data is invisible once count is zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count      <= 2'd0;
      head_pc    <= '0;
      head_instr <= '0;
      tail_pc    <= '0;
      tail_instr <= '0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) begin
            head_pc    <= push_pc;
            head_instr <= push_instr;
          end else begin
            tail_pc    <= push_pc;
            tail_instr <= push_instr;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          head_pc    <= tail_pc;
          head_instr <= tail_instr;
          count      <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            head_pc    <= push_pc;
            head_instr <= push_instr;
          end else begin
            head_pc    <= tail_pc;
            head_instr <= tail_instr;
            tail_pc    <= push_pc;
            tail_instr <= push_instr;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: single-outstanding request FSM feeding a 2-entry
// buffer. Optional delivered-instruction counter enabled by IF_PERF_CNT_EN.
module if_stage
  import riscv_pkg::*;
#(
  parameter int             XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
`ifdef IF_PERF_CNT_EN
  output logic [6:0]      if_opcode,
  output logic [XLEN-1:0] fetch_count
`else
  output logic [6:0]      if_opcode
`endif
);

  localparam logic [XLEN-1:0] RESET_PC_WORD = {RESET_PC[XLEN-1:2], 2'b00};

  fetch_state_t    state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] req_pc;
  logic            discard;
  logic [1:0]      count;
  logic [1:0]      count_next;
  logic            push;
  logic            pop;
  logic            granted;
  logic [XLEN-1:0] redirect_target;
  logic            unused_redirect_lsbs;

  assign redirect_target      = {redirect_pc[XLEN-1:2], 2'b00};
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  assign imem_addr  = pc;
  assign if_valid   = (count != 2'd0);
  assign if_opcode  = if_instr[6:0];
  assign granted    = (state == FETCH_REQ) && imem_req && imem_gnt;
  assign pop        = if_valid && if_ready && !redirect_valid;
  assign push       = (state == FETCH_WAIT) && imem_rvalid && !discard && !redirect_valid;
  assign count_next = count + {1'b0, push} - {1'b0, pop};

  // A redirect overrides everything; if a request is (or is becoming)
  // outstanding, its response must be swallowed before refetching.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= FETCH_REQ;
      pc       <= RESET_PC_WORD;
      req_pc   <= RESET_PC_WORD;
      discard  <= 1'b0;
      imem_req <= 1'b0;
    end else if (redirect_valid) begin
      pc <= redirect_target;
      if (granted || (state == FETCH_WAIT && !imem_rvalid)) begin
        state    <= FETCH_WAIT;
        discard  <= 1'b1;
        imem_req <= 1'b0;
      end else begin
        state    <= FETCH_REQ;
        discard  <= 1'b0;
        imem_req <= 1'b1;
      end
    end else begin
      case (state)
        FETCH_REQ: begin
          if (granted) begin
            req_pc   <= pc;
            pc       <= pc + XLEN'(4);
            state    <= FETCH_WAIT;
            imem_req <= 1'b0;
          end else begin
            imem_req <= 1'b1;
          end
        end
        FETCH_WAIT: begin
          if (imem_rvalid) begin
            discard <= 1'b0;
            if (count_next == 2'd2) begin
              state    <= FETCH_HOLD;
              imem_req <= 1'b0;
            end else begin
              state    <= FETCH_REQ;
              imem_req <= 1'b1;
            end
          end
        end
        FETCH_HOLD: begin
          if (count_next != 2'd2) begin
            state    <= FETCH_REQ;
            imem_req <= 1'b1;
          end
        end
        default: begin
          state    <= FETCH_REQ;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

  if_fifo #(.W(XLEN)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .pop        (pop),
    .flush      (redirect_valid),
    .push_pc    (req_pc),
    .push_instr (imem_rdata),
    .head_pc    (if_pc),
    .head_instr (if_instr),
    .count      (count)
  );

`ifdef IF_PERF_CNT_EN
  // Counts instructions actually handed to decode, across redirects.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count <= '0;
    end else if (pop) begin
      fetch_count <= fetch_count + XLEN'(1);
    end
  end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed self-checking bench for if_stage; a second instance exercises
// the address wrap from a high reset vector.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [6:0]  if_opcode;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [31:0] fetch_count2;
`endif

  logic        gnt_en;
  logic        resp_en;
  logic        pend = 1'b0;
  logic [31:0] pend_data = '0;

  logic        imem_req2;
  logic [31:0] imem_addr2;
  logic        imem_gnt2;
  logic        rvalid2 = 1'b0;
  logic [31:0] rdata2 = '0;
  logic        if_valid2;
  logic [31:0] if_instr2;
  logic [31:0] if_pc2;
  logic [6:0]  if_opcode2;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a + 32'h1000_0013;
  endfunction

  assign imem_gnt  = gnt_en & imem_req;
  assign imem_gnt2 = imem_req2;

  // Memory model: answers a grant on the next cycle, or parks it until resp_en.
  always @(posedge clk) begin
    imem_rvalid <= 1'b0;
    if (imem_req && imem_gnt) begin
      if (resp_en) begin
        imem_rvalid <= 1'b1;
        imem_rdata  <= instr_of(imem_addr);
      end else begin
        pend      <= 1'b1;
        pend_data <= instr_of(imem_addr);
      end
    end else if (pend && resp_en) begin
      imem_rvalid <= 1'b1;
      imem_rdata  <= pend_data;
      pend        <= 1'b0;
    end
  end

  always @(posedge clk) begin
    rvalid2 <= imem_req2 && imem_gnt2;
    rdata2  <= instr_of(imem_addr2);
  end

  if_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
`ifdef IF_PERF_CNT_EN
    .if_opcode      (if_opcode),
    .fetch_count    (fetch_count)
`else
    .if_opcode      (if_opcode)
`endif
  );

  if_stage #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req2),
    .imem_addr      (imem_addr2),
    .imem_gnt       (imem_gnt2),
    .imem_rvalid    (rvalid2),
    .imem_rdata     (rdata2),
    .redirect_valid (1'b0),
    .redirect_pc    (32'h0),
    .if_valid       (if_valid2),
    .if_ready       (1'b1),
    .if_instr       (if_instr2),
    .if_pc          (if_pc2),
`ifdef IF_PERF_CNT_EN
    .if_opcode      (if_opcode2),
    .fetch_count    (fetch_count2)
`else
    .if_opcode      (if_opcode2)
`endif
  );

  task automatic apply_reset();
    rst_n          = 1'b0;
    gnt_en         = 1'b1;
    resp_en        = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    if_ready       = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_valid(input int max, output bit ok);
    for (int i = 0; i < max && !if_valid; i++) @(negedge clk);
    ok = if_valid;
  endtask

  task automatic test_reset();
    rst_n          = 1'b0;
    gnt_en         = 1'b1;
    resp_en        = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    if_ready       = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (imem_req !== 1'b0) $display("[TB] FAIL rst_req: got %b expected 0", imem_req); else passes++;
    checks++; if (if_valid !== 1'b0) $display("[TB] FAIL rst_valid: got %b expected 0", if_valid); else passes++;
    checks++; if (if_pc !== 32'h0) $display("[TB] FAIL rst_pc: got %h expected 0", if_pc); else passes++;
    checks++; if (if_instr !== 32'h0) $display("[TB] FAIL rst_instr: got %h expected 0", if_instr); else passes++;
    checks++; if (imem_addr !== 32'h0) $display("[TB] FAIL rst_addr: got %h expected 0", imem_addr); else passes++;
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (imem_req !== 1'b1) $display("[TB] FAIL first_req: got %b expected 1", imem_req); else passes++;
    checks++; if (imem_addr !== 32'h0) $display("[TB] FAIL first_addr: got %h expected 0", imem_addr); else passes++;
    @(negedge clk);
    checks++; if (imem_rvalid !== 1'b1) $display("[TB] FAIL lat_rvalid: got %b expected 1", imem_rvalid); else passes++;
    checks++; if (if_valid !== 1'b0) $display("[TB] FAIL lat_early: got %b expected 0", if_valid); else passes++;
    @(negedge clk);
    checks++; if (if_valid !== 1'b1) $display("[TB] FAIL lat_valid: got %b expected 1", if_valid); else passes++;
    checks++; if (if_pc !== 32'h0) $display("[TB] FAIL lat_pc: got %h expected 0", if_pc); else passes++;
    checks++; if (if_instr !== 32'h1000_0013) $display("[TB] FAIL lat_instr: got %h expected 10000013", if_instr); else passes++;
    checks++; if (if_opcode !== 7'h13) $display("[TB] FAIL lat_opcode: got %h expected 13", if_opcode); else passes++;
  endtask

  task automatic test_stream();
    logic [31:0] pcs [3];
    int          cyc [3];
    int          n = 0;
    apply_reset();
    if_ready = 1'b1;
    for (int i = 0; i < 30 && n < 3; i++) begin
      @(negedge clk);
      if (if_valid && if_ready) begin
        pcs[n] = if_pc;
        cyc[n] = i;
        n++;
      end
    end
    checks++; if (n !== 3) $display("[TB] FAIL stream_count: got %0d expected 3", n); else passes++;
    if (n == 3) begin
      checks++; if (pcs[0] !== 32'h0) $display("[TB] FAIL stream_pc0: got %h expected 0", pcs[0]); else passes++;
      checks++; if (pcs[1] !== 32'h4) $display("[TB] FAIL stream_pc1: got %h expected 4", pcs[1]); else passes++;
      checks++; if (pcs[2] !== 32'h8) $display("[TB] FAIL stream_pc2: got %h expected 8", pcs[2]); else passes++;
      checks++; if (cyc[1] - cyc[0] !== 2) $display("[TB] FAIL stream_gap1: got %0d expected 2", cyc[1] - cyc[0]); else passes++;
      checks++; if (cyc[2] - cyc[1] !== 2) $display("[TB] FAIL stream_gap2: got %0d expected 2", cyc[2] - cyc[1]); else passes++;
    end
    if_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [31:0] pcs [2];
    int          n = 0;
    apply_reset();
    repeat (10) @(negedge clk);
    checks++; if (imem_req !== 1'b0) $display("[TB] FAIL bp_req: got %b expected 0", imem_req); else passes++;
    checks++; if (if_valid !== 1'b1) $display("[TB] FAIL bp_valid: got %b expected 1", if_valid); else passes++;
    checks++; if (if_pc !== 32'h0) $display("[TB] FAIL bp_pc: got %h expected 0", if_pc); else passes++;
    if_ready = 1'b1;
    for (int i = 0; i < 10 && n < 2; i++) begin
      if (if_valid && if_ready) begin
        pcs[n] = if_pc;
        n++;
      end
      @(negedge clk);
    end
    checks++; if (n !== 2) $display("[TB] FAIL bp_drain: got %0d expected 2", n); else passes++;
    if (n == 2) begin
      checks++; if (pcs[0] !== 32'h0) $display("[TB] FAIL bp_pc0: got %h expected 0", pcs[0]); else passes++;
      checks++; if (pcs[1] !== 32'h4) $display("[TB] FAIL bp_pc1: got %h expected 4", pcs[1]); else passes++;
    end
    if_ready = 1'b0;
  endtask

  task automatic test_redirect_wait();
    bit ok;
    apply_reset();
    resp_en = 1'b0;
    repeat (2) @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    @(negedge clk);
    redirect_valid = 1'b0;
    checks++; if (imem_req !== 1'b0) $display("[TB] FAIL rw_req_off: got %b expected 0", imem_req); else passes++;
    resp_en = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (imem_req !== 1'b1) $display("[TB] FAIL rw_req: got %b expected 1", imem_req); else passes++;
    checks++; if (imem_addr !== 32'h100) $display("[TB] FAIL rw_addr: got %h expected 100", imem_addr); else passes++;
    checks++; if (if_valid !== 1'b0) $display("[TB] FAIL rw_stale: got %b expected 0", if_valid); else passes++;
    wait_valid(10, ok);
    checks++; if (!ok) $display("[TB] FAIL rw_timeout: got 0 expected 1"); else passes++;
    checks++; if (if_pc !== 32'h100) $display("[TB] FAIL rw_pc: got %h expected 100", if_pc); else passes++;
    checks++; if (if_instr !== instr_of(32'h100)) $display("[TB] FAIL rw_instr: got %h expected %h", if_instr, instr_of(32'h100)); else passes++;
  endtask

  task automatic test_redirect_req();
    bit ok;
    bit stable = 1'b1;
    apply_reset();
    gnt_en = 1'b0;
    @(negedge clk);
    repeat (3) begin
      @(negedge clk);
      if (imem_req !== 1'b1 || imem_addr !== 32'h0) stable = 1'b0;
    end
    checks++; if (stable !== 1'b1) $display("[TB] FAIL req_hold: got %b expected 1", stable); else passes++;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0040;
    @(negedge clk);
    redirect_valid = 1'b0;
    checks++; if (imem_req !== 1'b1) $display("[TB] FAIL rr_req: got %b expected 1", imem_req); else passes++;
    checks++; if (imem_addr !== 32'h40) $display("[TB] FAIL rr_addr: got %h expected 40", imem_addr); else passes++;
    gnt_en = 1'b1;
    wait_valid(10, ok);
    checks++; if (!ok) $display("[TB] FAIL rr_timeout: got 0 expected 1"); else passes++;
    checks++; if (if_pc !== 32'h40) $display("[TB] FAIL rr_pc: got %h expected 40", if_pc); else passes++;
  endtask

  task automatic test_redirect_rvalid();
    bit ok;
    apply_reset();
    resp_en = 1'b0;
    repeat (2) @(negedge clk);
    resp_en = 1'b1;
    for (int i = 0; i < 5 && !imem_rvalid; i++) @(negedge clk);
    checks++; if (imem_rvalid !== 1'b1) $display("[TB] FAIL rv_seen: got %b expected 1", imem_rvalid); else passes++;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    @(negedge clk);
    redirect_valid = 1'b0;
    checks++; if (imem_req !== 1'b1) $display("[TB] FAIL rv_req: got %b expected 1", imem_req); else passes++;
    checks++; if (imem_addr !== 32'h200) $display("[TB] FAIL rv_addr: got %h expected 200", imem_addr); else passes++;
    checks++; if (if_valid !== 1'b0) $display("[TB] FAIL rv_drop: got %b expected 0", if_valid); else passes++;
    wait_valid(10, ok);
    checks++; if (!ok) $display("[TB] FAIL rv_timeout: got 0 expected 1"); else passes++;
    checks++; if (if_pc !== 32'h200) $display("[TB] FAIL rv_pc: got %h expected 200", if_pc); else passes++;
  endtask

  task automatic test_reset_mid();
    bit ok;
    apply_reset();
    wait_valid(10, ok);
    resp_en = 1'b0;
    for (int i = 0; i < 10 && !(imem_req && imem_gnt); i++) @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (if_valid !== 1'b0) $display("[TB] FAIL mid_rst_valid: got %b expected 0", if_valid); else passes++;
    rst_n   = 1'b1;
    resp_en = 1'b1;
    wait_valid(10, ok);
    checks++; if (!ok) $display("[TB] FAIL mid_timeout: got 0 expected 1"); else passes++;
    checks++; if (if_pc !== 32'h0) $display("[TB] FAIL mid_pc: got %h expected 0", if_pc); else passes++;
    checks++; if (if_instr !== instr_of(32'h0)) $display("[TB] FAIL mid_instr: got %h expected %h", if_instr, instr_of(32'h0)); else passes++;
  endtask

  task automatic test_wrap();
    logic [31:0] addrs [3];
    int          n = 0;
    apply_reset();
    for (int i = 0; i < 20 && n < 3; i++) begin
      @(negedge clk);
      if (imem_req2 && imem_gnt2) begin
        addrs[n] = imem_addr2;
        n++;
      end
    end
    checks++; if (n !== 3) $display("[TB] FAIL wrap_count: got %0d expected 3", n); else passes++;
    if (n == 3) begin
      checks++; if (addrs[0] !== 32'hFFFF_FFF8) $display("[TB] FAIL wrap_a0: got %h expected fffffff8", addrs[0]); else passes++;
      checks++; if (addrs[1] !== 32'hFFFF_FFFC) $display("[TB] FAIL wrap_a1: got %h expected fffffffc", addrs[1]); else passes++;
      checks++; if (addrs[2] !== 32'h0000_0000) $display("[TB] FAIL wrap_a2: got %h expected 00000000", addrs[2]); else passes++;
    end
  endtask

  task automatic test_perf();
`ifdef IF_PERF_CNT_EN
    int pops  = 0;
    bit redir = 1'b0;
    apply_reset();
    if_ready = 1'b1;
    for (int i = 0; i < 80 && pops < 5; i++) begin
      if (pops == 3 && !redir) begin
        if_ready       = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0080;
        @(negedge clk);
        redirect_valid = 1'b0;
        if_ready       = 1'b1;
        redir          = 1'b1;
      end
      if (if_valid && if_ready) pops++;
      @(negedge clk);
    end
    if_ready = 1'b0;
    @(negedge clk);
    checks++; if (pops !== 5) $display("[TB] FAIL perf_pops: got %0d expected 5", pops); else passes++;
    checks++; if (fetch_count !== 32'd5) $display("[TB] FAIL perf_count: got %0d expected 5", fetch_count); else passes++;
`else
    $display("[TB] perf counter not built, skipping");
`endif
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n          = 1'b0;
    gnt_en         = 1'b1;
    resp_en        = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    if_ready       = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_wait();
    test_redirect_req();
    test_redirect_rvalid();
    test_reset_mid();
    test_wrap();
    test_perf();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter XLEN, default 32, address/instruction width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 imem_req  output  1  instruction-memory request valid.
REQ-006 imem_addr  output  32  word-aligned fetch address; bits [1:0] always 2'b00.
REQ-007 imem_gnt  input  1  memory accepts request this cycle.
REQ-008 imem_rvalid  input  1  read data valid for oldest granted request.
REQ-009 imem_rdata  input  32  fetched instruction word.
REQ-010 redirect_valid  input  1  taken branch/jump from execute; one-cycle pulse.
REQ-011 redirect_pc  input  32  redirect target; bits [1:0] ignored.
REQ-012 if_valid  output  1  instruction available to decode.
REQ-013 if_ready  input  1  decode accepts instruction this cycle.
REQ-014 if_instr  output  32  buffered instruction word.
REQ-015 if_pc  output  32  address of if_instr.
REQ-016 if_opcode  output  7  if_instr[6:0], direct feed to decode control.
REQ-017 fetch_count  output  32  delivered-instruction counter (present only with IF_PERF_CNT_EN).

Function
REQ-018 FSM states: REQ (imem_req high, awaiting gnt), WAIT (one request outstanding, awaiting rvalid), HOLD (buffer cannot absorb another word, imem_req low).
REQ-019 At most one request outstanding; request issued only when buffer occupancy plus outstanding < 2.
REQ-020 imem_addr and imem_req held stable from assertion until the cycle imem_gnt is high.
REQ-021 On gnt: pc <= pc + 4 (mod 2^32, wraps 32'hFFFF_FFFC -> 0), state REQ -> WAIT.
REQ-022 On rvalid in WAIT: word plus its address pushed into 2-entry FIFO; next state REQ if space remains else HOLD.
REQ-023 if_valid = FIFO non-empty; pop on if_valid && if_ready; if_instr/if_pc/if_opcode from FIFO head, registered.
REQ-024 Latency: rvalid in cycle N -> if_valid in cycle N+1 when FIFO was empty.
REQ-025 Simultaneous push and pop at occupancy 1 keeps occupancy 1; push never occurs at occupancy 2.
REQ-026 redirect_valid has priority over push, pop, gnt: FIFO cleared, pc <= {redirect_pc[31:2],2'b00}, if_valid low next cycle.
REQ-027 Redirect while in WAIT (or same cycle as gnt): discard flag set; next rvalid dropped, flag cleared, then REQ at new pc.
REQ-028 Redirect coincident with rvalid: returned word dropped, no discard flag set.
REQ-029 Redirect in REQ before gnt: imem_addr changes to target next cycle (only allowed request abort).

Reset
REQ-030 rst_n low: pc=RESET_PC, state=REQ-pending, FIFO empty, discard=0, imem_req=0, if_valid=0, if_instr=0, if_pc=0, fetch_count=0.
REQ-031 First imem_req high in first clock edge after rst_n deassertion; reset mid-transaction abandons outstanding request, later rvalid ignored until a new gnt.

Configuration
REQ-032 Macro IF_PERF_CNT_EN defined: fetch_count increments by 1 per pop, wraps at 2^32, unaffected by redirect.
REQ-033 Macro undefined: fetch_count port and counter absent; all other behaviour identical.

Structure
REQ-034 Shared package riscv_pkg holds XLEN, RESET_PC default, opcode constants (RT, LW, SW, BEQ), fetch FSM state typedef.
REQ-035 One sub-module if_fifo: 2-entry {pc,instr} FIFO with push, pop, flush, count.

Verification
REQ-036 Reset release, gnt/rvalid each 1 cycle after request, if_ready=1 -> if_pc sequence 0x0,0x4,0x8, one instruction per 2 cycles.
REQ-037 if_ready=0 for 10 cycles -> occupancy 2, imem_req low, if_pc held 0x0; release -> 0x0,0x4 drained in order.
REQ-038 redirect_valid with redirect_pc=0x103 during WAIT -> stale rvalid word dropped, next imem_addr=0x100, next if_pc=0x100.
REQ-039 RESET_PC=32'hFFFF_FFF8 -> imem_addr 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
REQ-040 rst_n asserted while WAIT, rvalid arrives after release -> word not delivered, if_pc first = RESET_PC.
REQ-041 IF_PERF_CNT_EN defined, 5 pops with one redirect between -> fetch_count=5.
